// File: rtl/hue_pkg.sv
// Shared types and helpers for the hue wheel colour source.
package hue_pkg;

  localparam int NUM_SECTORS = 6;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5
  } sector_t;

  // Full-scale channel level for a given level width.
  function automatic int unsigned level_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Divides clk down to a one-cycle step strobe every STEP_INTERVAL enabled cycles.
module step_prescaler #(
  parameter int STEP_INTERVAL = 1200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic hold,
  output logic step
);

  localparam int CW = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
  localparam logic [CW-1:0] TC = CW'(STEP_INTERVAL - 1);

  logic [CW-1:0] cnt;

  // Strobe is combinational so the consumer acts on the same edge the count wraps.
  assign step = enable && !hold && (cnt == TC);

  // Count while enabled; hold parks the count at zero so a deferred step restarts a full interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (hold)   cnt <= '0;
    else if (enable) cnt <= (cnt == TC) ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/hue_sequencer.sv
// Hue wheel walker: steps a 6-sector wheel and offers RGB levels over valid/ready.
module hue_sequencer
  import hue_pkg::*;
#(
  parameter int STEP_INTERVAL = 1200,
  parameter int LEVEL_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               ready,
  output logic               valid,
  output logic [LEVEL_W-1:0] red_level,
  output logic [LEVEL_W-1:0] green_level,
  output logic [LEVEL_W-1:0] blue_level,
  output logic [2:0]         sector
);

  localparam logic [LEVEL_W-1:0] MAX  = LEVEL_W'(level_max(LEVEL_W));
  localparam logic [LEVEL_W-1:0] ZERO = '0;

  // Channel order in the packed level vector: [2]=red, [1]=green, [0]=blue.
  sector_t                  sec_q, sec_d;
  logic [LEVEL_W-1:0]       pos_q, pos_d;
  logic [2:0][LEVEL_W-1:0]  lvl_q, lvl_d;
  logic                     valid_q, valid_d;
  logic                     pend_q, pend_d;
  logic                     step, slot_free, adv;

  // Pending step freezes the prescaler so deferred steps are never doubled.
  step_prescaler #(.STEP_INTERVAL(STEP_INTERVAL)) u_presc (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .hold   (pend_q),
    .step   (step)
  );

  assign slot_free = !valid_q || ready;
  assign adv       = (step || pend_q) && slot_free;

  function automatic sector_t next_sector(input sector_t s);
    case (s)
      S0:      return S1;
      S1:      return S2;
      S2:      return S3;
      S3:      return S4;
      S4:      return S5;
      default: return S0;
    endcase
  endfunction

  // M-p stays within LEVEL_W bits since p never exceeds M.
  function automatic logic [3*LEVEL_W-1:0] level_map(input sector_t s,
                                                     input logic [LEVEL_W-1:0] p);
    case (s)
      S0:      return {MAX,     p,       ZERO};
      S1:      return {MAX - p, MAX,     ZERO};
      S2:      return {ZERO,    MAX,     p};
      S3:      return {ZERO,    MAX - p, MAX};
      S4:      return {p,       ZERO,    MAX};
      S5:      return {MAX,     ZERO,    MAX - p};
      default: return {MAX,     ZERO,    ZERO};
    endcase
  endfunction

  // Next-state: advance and load on a free slot, defer on a busy one, else drain.
  always_comb begin
    sec_d   = sec_q;
    pos_d   = pos_q;
    lvl_d   = lvl_q;
    valid_d = valid_q;
    pend_d  = pend_q;
    if (adv) begin
      if (pos_q == MAX) begin
        pos_d = ZERO;
        sec_d = next_sector(sec_q);
      end else begin
        pos_d = pos_q + LEVEL_W'(1);
      end
      lvl_d   = level_map(sec_d, pos_d);
      valid_d = 1'b1;
      pend_d  = 1'b0;
    end else if (step) begin
      pend_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  // State and output registers; reset discards any in-flight colour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q   <= S0;
      pos_q   <= ZERO;
      lvl_q   <= {MAX, ZERO, ZERO};
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      sec_q   <= sec_d;
      pos_q   <= pos_d;
      lvl_q   <= lvl_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
    end
  end

  assign valid       = valid_q;
  assign red_level   = lvl_q[2];
  assign green_level = lvl_q[1];
  assign blue_level  = lvl_q[0];
  assign sector      = sec_q;

endmodule

// File: tb/tb_hue_sequencer.sv
// Self-checking bench for hue_sequencer: directed scenarios plus a colour scoreboard.
module tb_hue_sequencer;

  localparam int SI = 4;
  localparam int LW = 8;

  logic clk    = 1'b0;
  logic rst_n  = 1'b1;
  logic enable = 1'b0;
  logic ready  = 1'b0;

  logic          valid, v1;
  logic [LW-1:0] red_level, green_level, blue_level, r1, g1, b1;
  logic [2:0]    sector, s1;
  logic [27:0]   obs, obs1;

  int n_checks = 0;
  int n_errs   = 0;
  logic [23:0] exp_q[$];
  int m_sec, m_pos;

  always #5 clk = ~clk;

  hue_sequencer #(.STEP_INTERVAL(SI), .LEVEL_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ready(ready), .valid(valid),
    .red_level(red_level), .green_level(green_level), .blue_level(blue_level),
    .sector(sector)
  );

  hue_sequencer #(.STEP_INTERVAL(1), .LEVEL_W(LW)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(1'b1), .ready(1'b1), .valid(v1),
    .red_level(r1), .green_level(g1), .blue_level(b1), .sector(s1)
  );

  assign obs  = {valid, sector, red_level, green_level, blue_level};
  assign obs1 = {v1, s1, r1, g1, b1};

  function automatic logic [23:0] colour(input int s, input int p);
    logic [7:0] pp, mm;
    pp = p[7:0];
    mm = 8'd255 - pp;
    case (s)
      0:       return {8'd255, pp, 8'd0};
      1:       return {mm, 8'd255, 8'd0};
      2:       return {8'd0, 8'd255, pp};
      3:       return {8'd0, mm, 8'd255};
      4:       return {pp, 8'd0, 8'd255};
      default: return {8'd255, 8'd0, mm};
    endcase
  endfunction

  task automatic push_next();
    if (m_pos == 255) begin
      m_pos = 0;
      m_sec = (m_sec + 1) % 6;
    end else begin
      m_pos = m_pos + 1;
    end
    exp_q.push_back(colour(m_sec, m_pos));
  endtask

  // Advance n cycles; colours accepted by the downstream are scored at the negedge before the edge.
  task automatic tick(input int n);
    logic [23:0] e;
    repeat (n) begin
      @(negedge clk);
      if (rst_n && valid && ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errs++;
          $display("FAIL sb_extra: got %h required no colour", obs[23:0]);
        end else begin
          e = exp_q.pop_front();
          if (obs[23:0] !== e) begin
            n_errs++;
            $display("FAIL sb_colour: got %h required %h", obs[23:0], e);
          end
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_sec = 0;
    m_pos = 0;
    exp_q.delete();
    tick(1);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    enable = 1'b1;
    ready  = 1'b1;
    m_sec = 0;
    m_pos = 0;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 28'h0FF0000) begin n_errs++; $display("FAIL reset_state: got %h required %h", obs, 28'h0FF0000); end
    tick(1);
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      n_checks++;
      if (obs !== 28'h0FF0000) begin n_errs++; $display("FAIL reset_idle%0d: got %h required %h", i, obs, 28'h0FF0000); end
    end
    push_next();
    tick(1);
    n_checks++;
    if (obs !== 28'h8FF0100) begin n_errs++; $display("FAIL first_step: got %h required %h", obs, 28'h8FF0100); end
    tick(1);
    n_checks++;
    if (obs !== 28'h0FF0100) begin n_errs++; $display("FAIL drain_hold: got %h required %h", obs, 28'h0FF0100); end
    n_checks++;
    if (exp_q.size() != 0) begin n_errs++; $display("FAIL reset_sb_empty: got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    do_reset();
    enable = 1'b1;
    ready  = 1'b0;
    tick(4);
    n_checks++;
    if (obs !== 28'h8FF0100) begin n_errs++; $display("FAIL bp_load: got %h required %h", obs, 28'h8FF0100); end
    tick(4);
    n_checks++;
    if (obs !== 28'h8FF0100) begin n_errs++; $display("FAIL bp_hold1: got %h required %h", obs, 28'h8FF0100); end
    tick(4);
    n_checks++;
    if (obs !== 28'h8FF0100) begin n_errs++; $display("FAIL bp_hold2: got %h required %h", obs, 28'h8FF0100); end
    ready = 1'b1;
    push_next();
    push_next();
    tick(1);
    n_checks++;
    if (obs !== 28'h8FF0200) begin n_errs++; $display("FAIL bp_release: got %h required %h", obs, 28'h8FF0200); end
    tick(1);
    n_checks++;
    if (obs !== 28'h0FF0200) begin n_errs++; $display("FAIL bp_drain: got %h required %h", obs, 28'h0FF0200); end
    tick(2);
    n_checks++;
    if (obs !== 28'h0FF0200) begin n_errs++; $display("FAIL bp_restart_wait: got %h required %h", obs, 28'h0FF0200); end
    push_next();
    tick(1);
    n_checks++;
    if (obs !== 28'h8FF0300) begin n_errs++; $display("FAIL bp_resume: got %h required %h", obs, 28'h8FF0300); end
    tick(1);
    n_checks++;
    if (exp_q.size() != 0) begin n_errs++; $display("FAIL bp_sb_empty: got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_enable();
    do_reset();
    enable = 1'b1;
    ready  = 1'b0;
    tick(4);
    n_checks++;
    if (obs !== 28'h8FF0100) begin n_errs++; $display("FAIL en_load: got %h required %h", obs, 28'h8FF0100); end
    tick(2);
    enable = 1'b0;
    tick(3);
    n_checks++;
    if (obs !== 28'h8FF0100) begin n_errs++; $display("FAIL en_frozen: got %h required %h", obs, 28'h8FF0100); end
    ready = 1'b1;
    push_next();
    tick(1);
    n_checks++;
    if (obs !== 28'h0FF0100) begin n_errs++; $display("FAIL en_drain: got %h required %h", obs, 28'h0FF0100); end
    tick(6);
    n_checks++;
    if (obs !== 28'h0FF0100) begin n_errs++; $display("FAIL en_idle: got %h required %h", obs, 28'h0FF0100); end
    enable = 1'b1;
    tick(1);
    n_checks++;
    if (obs !== 28'h0FF0100) begin n_errs++; $display("FAIL en_remaining: got %h required %h", obs, 28'h0FF0100); end
    push_next();
    tick(1);
    n_checks++;
    if (obs !== 28'h8FF0200) begin n_errs++; $display("FAIL en_step: got %h required %h", obs, 28'h8FF0200); end
    tick(1);
    n_checks++;
    if (exp_q.size() != 0) begin n_errs++; $display("FAIL en_sb_empty: got %0d required 0", exp_q.size()); end
  endtask

  // Whole wheel with ready high: every colour is scored, boundaries checked against fixed values.
  task automatic test_wheel();
    logic [27:0] req;
    do_reset();
    enable = 1'b1;
    ready  = 1'b1;
    for (int k = 1; k <= 1536; k++) begin
      push_next();
      tick(4);
      if (k == 255 || k == 256 || k == 257 || k == 1535 || k == 1536) begin
        case (k)
          255:     req = 28'h8FFFF00;
          256:     req = 28'h9FFFF00;
          257:     req = 28'h9FEFF00;
          1535:    req = 28'hDFF0000;
          default: req = 28'h8FF0000;
        endcase
        n_checks++;
        if (obs !== req) begin n_errs++; $display("FAIL wheel_step%0d: got %h required %h", k, obs, req); end
      end
    end
    tick(1);
    n_checks++;
    if (exp_q.size() != 0) begin n_errs++; $display("FAIL wheel_sb_empty: got %0d required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    enable = 1'b1;
    ready  = 1'b0;
    tick(4);
    n_checks++;
    if (obs !== 28'h8FF0100) begin n_errs++; $display("FAIL rm_load: got %h required %h", obs, 28'h8FF0100); end
    tick(2);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 28'h0FF0000) begin n_errs++; $display("FAIL rm_async: got %h required %h", obs, 28'h0FF0000); end
    m_sec = 0;
    m_pos = 0;
    exp_q.delete();
    tick(1);
    rst_n = 1'b1;
    ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      n_checks++;
      if (obs !== 28'h0FF0000) begin n_errs++; $display("FAIL rm_idle%0d: got %h required %h", i, obs, 28'h0FF0000); end
    end
    push_next();
    tick(1);
    n_checks++;
    if (obs !== 28'h8FF0100) begin n_errs++; $display("FAIL rm_first_step: got %h required %h", obs, 28'h8FF0100); end
    tick(1);
    n_checks++;
    if (exp_q.size() != 0) begin n_errs++; $display("FAIL rm_sb_empty: got %0d required 0", exp_q.size()); end
  endtask

  // Interval of one: a new colour every cycle with ready tied high.
  task automatic test_interval1();
    logic [27:0] req;
    logic [7:0]  g;
    enable = 1'b0;
    ready  = 1'b0;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      g   = 8'(k);
      req = {4'h8, 8'hFF, g, 8'h00};
      n_checks++;
      if (obs1 !== req) begin n_errs++; $display("FAIL si1_step%0d: got %h required %h", k, obs1, req); end
    end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_enable();
    test_wheel();
    test_reset_mid();
    test_interval1();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/hue_sequencer.md
Name: hue_sequencer

Overview:
Upstream colour source for the RGB PWM stage. Walks a 6-sector hue wheel one position per STEP_INTERVAL clocks and presents per-channel duty levels (red/green/blue) over a valid/ready handshake. The downstream PWM block asserts ready when it can latch a new duty set, normally at a PWM period boundary. Replaces fixed per-light initial-state parameters with one coordinated colour source.

Parameters:
STEP_INTERVAL, 1200, clk cycles between hue steps (>=1)
LEVEL_W, 8, bits per channel level; positions per sector = 2**LEVEL_W

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  1 = prescaler runs; 0 = prescaler frozen (handshake still active)
ready  input  1  downstream accepts current levels this cycle
valid  output  1  red/green/blue_level hold an unconsumed colour
red_level  output  LEVEL_W  red duty level, 0 = off, 2**LEVEL_W-1 = full
green_level  output  LEVEL_W  green duty level
blue_level  output  LEVEL_W  blue duty level
sector  output  3  current hue sector, 0..5 (debug/status)

Behaviour:
- Reset (async assert, sync release): prescaler=0, sector=S0, pos=0, red=MAX, green=0, blue=0, valid=0, pending=0. MAX = 2**LEVEL_W-1.
- Prescaler counts 0..STEP_INTERVAL-1 while enable=1. At terminal count it wraps to 0 and raises step.
- Slot free when valid==0 or ready==1.
- Step with slot free: on that same edge, pos/sector advance and output registers load the levels of the new position. valid=1.
- Step with slot busy (valid=1, ready=0): pending=1. Prescaler holds at 0 until pending clears, so no step is ever lost or doubled.
- pending=1 and slot becomes free: advance and load on that edge; pending=0; prescaler resumes next cycle.
- valid&&ready with no step and no pending: valid=0 next edge; levels hold their values.
- Advance: pos+1. If pos==MAX: pos=0 and sector=next (S5 -> S0).
- Level map, p=pos, M=MAX:
  - S0: r=M, g=p, b=0
  - S1: r=M-p, g=M, b=0
  - S2: r=0, g=M, b=p
  - S3: r=0, g=M-p, b=M
  - S4: r=p, g=0, b=M
  - S5: r=M, g=0, b=M-p
- Sector boundaries repeat one colour (e.g. S0 p=M equals S1 p=0). This is intentional. A full wheel is 6*2**LEVEL_W steps.
- enable=0: prescaler and pending hold. Pending may still complete when the slot frees. Outputs and handshake are unaffected.
- STEP_INTERVAL=1: step every cycle; with ready tied high, valid stays 1 and the level changes each cycle.
- rst_n low mid-operation: all state returns to reset values immediately (asynchronous). An in-flight colour is discarded.
- Output levels are registered; no combinational path from ready to the levels. valid depends only on registered state.
- Width rule: M-p is computed in LEVEL_W bits, with no underflow because p<=M.

Decomposition:
- Shared package hue_pkg:
  - sector_t enum {S0..S5} encoded 3'd0..3'd5
  - NUM_SECTORS=6
  - function level_max(LEVEL_W)
- Sub-module step_prescaler:
  - parameter STEP_INTERVAL
  - ports clk, rst_n, enable, hold → step pulse
  - hold freezes the count at 0
- Hue FSM, level map and handshake register stay in hue_sequencer.

Test Plan:
- Reset release, STEP_INTERVAL=4, enable=1, ready=1: valid=0 for cycles 1-3. At edge 4 valid=1 with (255,1,0), sector=0.
- Backpressure: ready=0 across two intervals. Levels stay (255,1,0) and pending=1. On ready=1: the next edge gives (255,2,0), then intervals resume — no skipped position.
- Wrap: preload run to S5 pos=255 (255,0,0), then one step. Required: sector=0, (255,0,0). Full wheel = 1536 steps back to start.
- Sector transition S0 p=255 → S1 p=0 → S1 p=1. Required levels: (255,255,0), (255,255,0), (254,255,0).
- enable=0 for 10 cycles mid-interval: prescaler frozen, valid/levels unchanged, with handshake still draining valid. Re-enable: the step arrives after the remaining count only.
- rst_n pulsed low mid-interval with valid=1, ready=0. Required: the same cycle gives valid=0, (255,0,0), sector=0. Behaviour after release is identical to the first scenario.
